// File: rtl/load_cache_arbiter.sv
// Round-robin arbiter sharing one data-cache read port among N_REQ load stations.
// Holds the port through a miss stall, then returns the word with a one-cycle ack.
module load_cache_arbiter #(
  parameter int N_REQ     = 2,
  parameter int WORD_SIZE = 32,
  parameter int MEM_STALL = 4,
  parameter int IDX_W     = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*WORD_SIZE-1:0] addr,
  input  logic [N_REQ-1:0]           cancel,
  output logic [N_REQ-1:0]           ack,
  output logic [WORD_SIZE-1:0]       rdata,
  output logic                       busy,
  output logic [WORD_SIZE-1:0]       c_ptr,
  output logic                       c_read_enable,
  input  logic [WORD_SIZE-1:0]       c_out,
  input  logic                       c_hit
);

  localparam int CNT_W = $clog2(MEM_STALL + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    STALL  = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t               state;
  state_t               next_state;
  logic [IDX_W-1:0]     owner;
  logic [IDX_W-1:0]     rr_ptr;
  logic [IDX_W-1:0]     rr_after_owner;
  logic [IDX_W-1:0]     winner;
  logic [CNT_W-1:0]     stall_cnt;
  logic [WORD_SIZE-1:0] win_addr;
  logic [N_REQ-1:0]     eff;
  logic                 grant_valid;
  logic                 owner_cancel;

  // Round-robin search: first eligible station at or above rr_ptr, wrapping
  always_comb begin
    eff         = req & ~cancel;
    grant_valid = 1'b0;
    winner      = '0;
    win_addr    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      for (int j = 0; j < N_REQ; j++) begin
        if (!grant_valid && eff[j] && (((int'(rr_ptr) + i) % N_REQ) == j)) begin
          grant_valid = 1'b1;
          winner      = IDX_W'(j);
          win_addr    = addr[j*WORD_SIZE +: WORD_SIZE];
        end else begin
          grant_valid = grant_valid;
        end
      end
    end
  end

  // Owner-relative helpers: its cancel bit and the pointer one past it
  always_comb begin
    owner_cancel = 1'b0;
    for (int j = 0; j < N_REQ; j++) begin
      if (owner == IDX_W'(j)) begin
        owner_cancel = cancel[j];
      end else begin
        owner_cancel = owner_cancel;
      end
    end
    if (owner == IDX_W'(N_REQ - 1)) begin
      rr_after_owner = '0;
    end else begin
      rr_after_owner = owner + IDX_W'(1);
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; a cancel of the owner aborts straight back to IDLE
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (grant_valid) next_state = LOOKUP;
        else             next_state = IDLE;
      end
      LOOKUP: begin
        if (owner_cancel) next_state = IDLE;
        else if (c_hit)   next_state = RESP;
        else              next_state = STALL;
      end
      STALL: begin
        if (owner_cancel)           next_state = IDLE;
        else if (stall_cnt == '0)   next_state = RESP;
        else                        next_state = STALL;
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath registers: grant capture, stall countdown, data return
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner         <= '0;
      rr_ptr        <= '0;
      stall_cnt     <= '0;
      rdata         <= '0;
      c_ptr         <= '0;
      c_read_enable <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            owner         <= winner;
            c_ptr         <= win_addr;
            c_read_enable <= 1'b1;
          end
        end
        LOOKUP: begin
          if (owner_cancel) begin
            c_read_enable <= 1'b0;
            rr_ptr        <= rr_after_owner;
          end else if (c_hit) begin
            rdata         <= c_out;
            c_read_enable <= 1'b0;
          end else begin
            stall_cnt     <= CNT_W'(MEM_STALL - 1);
          end
        end
        STALL: begin
          if (owner_cancel) begin
            c_read_enable <= 1'b0;
            rr_ptr        <= rr_after_owner;
          end else if (stall_cnt == '0) begin
            rdata         <= c_out;
            c_read_enable <= 1'b0;
          end else begin
            stall_cnt     <= stall_cnt - CNT_W'(1);
          end
        end
        RESP: begin
          rr_ptr <= rr_after_owner;
        end
        default: begin
          c_read_enable <= 1'b0;
        end
      endcase
    end
  end

  // Outputs decoded from registered state only
  always_comb begin
    busy = (state != IDLE);
    ack  = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if ((state == RESP) && (owner == IDX_W'(j))) begin
        ack[j] = 1'b1;
      end else begin
        ack[j] = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_load_cache_arbiter.sv
// Self-checking bench for load_cache_arbiter: directed scenarios with literal
// expectations, then randomized traffic against a transaction-level model.
module tb_load_cache_arbiter;

  localparam int N  = 2;
  localparam int W  = 32;
  localparam int MS = 4;

  logic           clk;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] addr;
  logic [N-1:0]   cancel;
  logic [N-1:0]   ack;
  logic [W-1:0]   rdata;
  logic           busy;
  logic [W-1:0]   c_ptr;
  logic           c_read_enable;
  logic [W-1:0]   c_out;
  logic           c_hit;
  logic [W-1:0]   a [N];

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  load_cache_arbiter #(.N_REQ(N), .WORD_SIZE(W), .MEM_STALL(MS), .IDX_W(3)) dut (
    .clk(clk), .reset(reset), .req(req), .addr(addr), .cancel(cancel),
    .ack(ack), .rdata(rdata), .busy(busy), .c_ptr(c_ptr),
    .c_read_enable(c_read_enable), .c_out(c_out), .c_hit(c_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) addr[i*W +: W] = a[i];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // ---------------- transaction-level reference model ----------------
  bit           m_active, m_resp;
  int           m_owner, m_age, m_rr;
  logic [W-1:0] m_rdata, m_cptr;
  logic [N-1:0] m_ack;

  function automatic int rr_pick(input logic [N-1:0] eligible, input int start);
    for (int k = 0; k < N; k++) begin
      if (eligible[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_active <= 1'b0; m_resp <= 1'b0; m_owner <= 0; m_age <= 0; m_rr <= 0;
      m_rdata <= '0; m_cptr <= '0;
    end else if (m_resp) begin
      m_resp <= 1'b0;
      m_rr   <= (m_owner + 1) % N;
    end else if (m_active) begin
      if (cancel[m_owner]) begin
        m_active <= 1'b0;
        m_rr     <= (m_owner + 1) % N;
      end else if ((m_age == 0 && c_hit) || m_age == MS) begin
        m_rdata  <= c_out;
        m_active <= 1'b0;
        m_resp   <= 1'b1;
      end else begin
        m_age <= m_age + 1;
      end
    end else if (rr_pick(req & ~cancel, m_rr) >= 0) begin
      m_owner  <= rr_pick(req & ~cancel, m_rr);
      m_cptr   <= a[rr_pick(req & ~cancel, m_rr)];
      m_active <= 1'b1;
      m_age    <= 0;
    end
  end

  always_comb begin
    m_ack = '0;
    if (m_resp) m_ack[m_owner] = 1'b1;
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("m_ack",   64'(ack),           64'(m_ack));
      check("m_busy",  64'(busy),          64'(m_active | m_resp));
      check("m_cre",   64'(c_read_enable), 64'(m_active));
      check("m_cptr",  64'(c_ptr),         64'(m_cptr));
      check("m_rdata", 64'(rdata),         64'(m_rdata));
    end
  end

  // ---------------- stimulus ----------------
  int           cre_cnt, ack_at, n;
  logic [N-1:0] got_ack;
  logic [W-1:0] got_rd;
  logic [N-1:0] acks [4];
  int           times [4];

  initial begin
    reset = 1'b0; req = '0; cancel = '0; c_hit = 1'b0; c_out = '0;
    for (int i = 0; i < N; i++) a[i] = '0;
    cmp_en = 1'b1;
    repeat (3) tick();
    check("rst_ack", 64'(ack), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_cre", 64'(c_read_enable), 64'd0);
    check("rst_cptr", 64'(c_ptr), 64'd0);
    check("rst_rdata", 64'(rdata), 64'd0);
    reset = 1'b1;
    tick();

    // single hit
    req = 2'b01; a[0] = 32'h40; c_hit = 1'b1; c_out = 32'h1234;
    tick();
    check("hit_cre", 64'(c_read_enable), 64'd1);
    check("hit_cptr", 64'(c_ptr), 64'h40);
    check("hit_busy", 64'(busy), 64'd1);
    tick();
    check("hit_ack", 64'(ack), 64'b01);
    check("hit_rdata", 64'(rdata), 64'h1234);
    check("hit_cre_low", 64'(c_read_enable), 64'd0);
    req = 2'b00;
    tick();
    check("hit_idle_busy", 64'(busy), 64'd0);

    // miss on station 1
    req = 2'b10; a[1] = 32'h80; c_hit = 1'b0; c_out = 32'hBEEF;
    cre_cnt = 0; ack_at = -1; got_ack = '0; got_rd = '0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (c_read_enable) cre_cnt++;
      if (ack != '0 && ack_at < 0) begin
        ack_at = k; got_ack = ack; got_rd = rdata; req = 2'b00;
      end
    end
    check("miss_cre_cycles", 64'(cre_cnt), 64'd5);
    check("miss_latency", 64'(ack_at), 64'd6);
    check("miss_ack", 64'(got_ack), 64'b10);
    check("miss_rdata", 64'(got_rd), 64'hBEEF);

    // contention, rr_ptr back at 0
    req = 2'b11; a[0] = 32'h44; a[1] = 32'h88; c_hit = 1'b1; c_out = 32'h5555;
    n = 0;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (ack != '0 && n < 4) begin
        acks[n] = ack; times[n] = k; n++;
        if (n == 4) req = 2'b00;
      end
    end
    check("cont_count", 64'(n), 64'd4);
    if (n == 4) begin
      check("cont_g0", 64'(acks[0]), 64'b01);
      check("cont_g1", 64'(acks[1]), 64'b10);
      check("cont_g2", 64'(acks[2]), 64'b01);
      check("cont_g3", 64'(acks[3]), 64'b10);
      check("cont_first", 64'(times[0]), 64'd2);
      for (int i = 1; i < 4; i++) check("cont_gap", 64'(times[i] - times[i-1]), 64'd3);
    end

    // cancel of station 0 on its 2nd stall cycle, station 1 pending
    req = 2'b11; a[0] = 32'h100; a[1] = 32'h200; c_hit = 1'b0;
    repeat (3) tick();
    cancel = 2'b01; req = 2'b10;
    tick();
    check("cxl_cre", 64'(c_read_enable), 64'd0);
    check("cxl_ack", 64'(ack), 64'd0);
    check("cxl_busy", 64'(busy), 64'd0);
    cancel = 2'b00;
    tick();
    check("cxl_next_cre", 64'(c_read_enable), 64'd1);
    check("cxl_next_cptr", 64'(c_ptr), 64'h200);
    c_hit = 1'b1; c_out = 32'h7777;
    tick();
    check("cxl_next_ack", 64'(ack), 64'b10);
    req = 2'b00;
    tick();

    // async reset in the middle of a stall
    req = 2'b01; a[0] = 32'h300; c_hit = 1'b0;
    repeat (3) tick();
    #2 reset = 1'b0;
    #1;
    check("arst_cre", 64'(c_read_enable), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_ack", 64'(ack), 64'd0);
    req = 2'b00;
    tick();
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("arst_no_ack", 64'(ack), 64'd0);
      check("arst_idle", 64'(busy), 64'd0);
    end

    // randomized traffic obeying the station protocol
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      if ($urandom_range(0, 999) == 0) begin
        #2 reset = 1'b0;
        req = '0; cancel = '0;
        tick();
        reset = 1'b1;
      end else begin
        cancel = '0;
        for (int i = 0; i < N; i++) begin
          if (req[i] && m_ack[i]) begin
            req[i] = 1'b0;
          end else if (req[i] && $urandom_range(0, 39) == 0) begin
            cancel[i] = 1'b1; req[i] = 1'b0;
          end else if (!req[i] && $urandom_range(0, 2) == 0) begin
            req[i] = 1'b1; a[i] = $urandom;
          end
        end
        c_hit = 1'($urandom_range(0, 1));
        c_out = $urandom;
      end
    end

    tick();
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
